// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one line-wide physical-memory port between the L1
// instruction cache and the L1 data cache. Grants one requester at a time in
// round-robin order, latches the winner's command until pmem_resp, and routes
// the completion back to the owner only.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic                  i_pmem_read,
  input  logic                  i_pmem_write,
  input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,

  output logic [1:0]            owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t state;
  grant_t last_grant;

  logic i_active;
  logic d_active;
  logic pick_i;
  logic pick_d;

  assign i_active = i_pmem_read | i_pmem_write;
  assign d_active = d_pmem_read | d_pmem_write;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  assign pick_i = i_active & (~d_active | (last_grant == GRANT_D));
  assign pick_d = d_active & ~pick_i;

  // Arbitration FSM with the latched memory command as registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: every register in this block is assigned with <= so all of them
    // see the pre-edge values; a blocking = here would let later statements
    // observe freshly updated state and break the FSM's edge semantics.
    if (rst) begin
      state        <= IDLE;
      last_grant   <= GRANT_D;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_i) begin
            state        <= SERVE_I;
            last_grant   <= GRANT_I;
            pmem_address <= i_pmem_address;
            pmem_wdata   <= i_pmem_wdata;
            pmem_write   <= i_pmem_write;
            // Write takes precedence when a cache raises both strobes.
            pmem_read    <= i_pmem_read & ~i_pmem_write;
          end else if (pick_d) begin
            state        <= SERVE_D;
            last_grant   <= GRANT_D;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            pmem_write   <= d_pmem_write;
            pmem_read    <= d_pmem_read & ~d_pmem_write;
          end
        end
        SERVE_I, SERVE_D: begin
          // Command stays frozen until memory completes, even if the owner
          // has dropped its request in the meantime.
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion goes only to the current owner, and only while it still asks.
  assign i_pmem_resp = pmem_resp & (state == SERVE_I) & i_active;
  assign d_pmem_resp = pmem_resp & (state == SERVE_D) & d_active;

  // Read data is broadcast; the resp lines qualify it.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  assign owner = {state == SERVE_D, state == SERVE_I};

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios followed by random
// traffic from both caches, checked by a transaction-level round-robin model.
module tb_pmem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_pmem_address, d_pmem_address;
  logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
  logic [LW-1:0] i_pmem_wdata, d_pmem_wdata;
  logic [LW-1:0] i_pmem_rdata, d_pmem_rdata;
  logic          i_pmem_resp, d_pmem_resp;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [1:0]    owner;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_write(i_pmem_write), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // One outstanding memory command as a cache asked for it.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [LW-1:0] wdata;
  } cmd_t;

  cmd_t i_q[$];
  cmd_t d_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Memory model controls, written only by the main sequence.
  bit mem_auto   = 1'b1;
  bit mem_fixed  = 1'b1;
  int stray_req  = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit is_d, input logic [AW-1:0] a, input logic r, input logic w,
                         input logic [LW-1:0] wd);
    if (is_d) begin
      d_pmem_address = a; d_pmem_read = r; d_pmem_write = w; d_pmem_wdata = wd;
    end else begin
      i_pmem_address = a; i_pmem_read = r; i_pmem_write = w; i_pmem_wdata = wd;
    end
  endtask

  task automatic push_req(input bit is_d, input logic [AW-1:0] a, input logic r, input logic w,
                          input logic [LW-1:0] wd);
    cmd_t c;
    c.addr  = a;
    c.rd    = r & ~w;
    c.wr    = w;
    c.wdata = wd;
    if (is_d) d_q.push_back(c);
    else      i_q.push_back(c);
  endtask

  // Cache-side requester: hold the request until resp, or drop it after
  // drop_after owned cycles when drop_after > 0. Called at posedge+1.
  task automatic do_req(input bit is_d, input logic [AW-1:0] a, input logic r, input logic w,
                        input logic [LW-1:0] wd, input int drop_after);
    int  owned;
    int  waited;
    bit  done;
    bit  dropped;
    logic [1:0] me;
    owned = 0; waited = 0; done = 1'b0; dropped = 1'b0;
    me = is_d ? 2'b10 : 2'b01;
    set_req(is_d, a, r, w, wd);
    push_req(is_d, a, r, w, wd);
    while (!done) begin
      @(negedge clk);
      waited++;
      if (is_d ? d_pmem_resp : i_pmem_resp) begin
        done = 1'b1;
      end else begin
        if (owner == me) owned++;
        if (drop_after > 0 && owned >= drop_after) begin
          done = 1'b1; dropped = 1'b1;
        end else if (waited > 300) begin
          vectors++; miscompares++;
          $display("FAIL req_timeout: cache %0d got no resp for %h", is_d, a);
          done = 1'b1;
        end
      end
    end
    next_cycle();
    if (is_d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    else      begin i_pmem_read = 1'b0; i_pmem_write = 1'b0; end
    if (dropped) begin
      // Wait out the abandoned memory transaction before asking again.
      for (int k = 0; k < 50 && owner == me; k++) next_cycle();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic rand_traffic(input bit is_d, input int n);
    for (int k = 0; k < n; k++) begin
      int op, gap, drop;
      logic [AW-1:0] a;
      op   = $urandom_range(0, 7);
      gap  = $urandom_range(0, 3);
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      a    = 16'($urandom());
      do_req(is_d, a, (op == 0) || (op > 3), (op <= 3), rand_line(), drop);
      for (int g = 0; g < gap; g++) next_cycle();
    end
  endtask

  // Memory model: responds a number of cycles after a command appears;
  // forgets a command that vanishes (reset). Manual mode only emits strays.
  initial begin
    bit active;
    int cnt;
    int stray_seen;
    active = 1'b0; cnt = 0; stray_seen = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      next_cycle();
      pmem_rdata = mem_fixed ? {4{32'hA5A5A5A5}} : rand_line();
      if (mem_auto) begin
        pmem_resp = 1'b0;
        if (!(pmem_read | pmem_write)) begin
          active = 1'b0;
        end else if (!active) begin
          active = 1'b1;
          cnt = mem_fixed ? 5 : $urandom_range(0, 5);
        end
        if (active) begin
          if (cnt == 0) begin
            pmem_resp = 1'b1;
            active = 1'b0;
          end else begin
            cnt--;
          end
        end
      end else begin
        active = 1'b0;
        pmem_resp = (stray_req != stray_seen);
        stray_seen = stray_req;
      end
    end
  end

  // Reference model and monitor: at each negedge, apply the rules to what was
  // visible just before the edge that passed, then compare every output.
  initial begin
    bit   busy, cur, last, win;
    bit   p_rst, p_i, p_d, p_resp;
    cmd_t exp_cmd;
    busy = 1'b0; cur = 1'b0; last = 1'b1;
    p_rst = 1'b1; p_i = 1'b0; p_d = 1'b0; p_resp = 1'b0;
    exp_cmd = '0;
    forever begin
      @(negedge clk);
      if (p_rst) begin
        busy = 1'b0;
        last = 1'b1;
      end else if (busy) begin
        if (p_resp) busy = 1'b0;
      end else if (p_i || p_d) begin
        win = (p_i && p_d) ? ~last : p_d;
        if ((win && d_q.size() == 0) || (!win && i_q.size() == 0)) begin
          vectors++; miscompares++;
          $display("FAIL scoreboard_empty: grant to cache %0d with nothing queued", win);
          exp_cmd = '0;
        end else begin
          exp_cmd = win ? d_q.pop_front() : i_q.pop_front();
        end
        busy = 1'b1; cur = win; last = win;
      end

      check("owner", owner, busy ? (cur ? 2'b10 : 2'b01) : 2'b00);
      check("pmem_read", pmem_read, busy & exp_cmd.rd);
      check("pmem_write", pmem_write, busy & exp_cmd.wr);
      if (busy) begin
        check("pmem_address", pmem_address, exp_cmd.addr);
        check("pmem_wdata", pmem_wdata, exp_cmd.wdata);
      end else if (p_rst) begin
        check("reset_address", pmem_address, '0);
        check("reset_wdata", pmem_wdata, '0);
      end
      check("i_pmem_resp", i_pmem_resp, pmem_resp & busy & ~cur & (i_pmem_read | i_pmem_write));
      check("d_pmem_resp", d_pmem_resp, pmem_resp & busy & cur & (d_pmem_read | d_pmem_write));
      check("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
      check("d_pmem_rdata", d_pmem_rdata, pmem_rdata);

      p_rst  = rst;
      p_i    = i_pmem_read | i_pmem_write;
      p_d    = d_pmem_read | d_pmem_write;
      p_resp = pmem_resp;
    end
  end

  // Main sequence.
  initial begin
    rst = 1'b1;
    set_req(1'b0, '0, 1'b0, 1'b0, '0);
    set_req(1'b1, '0, 1'b0, 1'b0, '0);
    repeat (3) next_cycle();
    rst = 1'b0;
    next_cycle();

    // Lone I read, memory answers after 5 cycles with A5 pattern.
    do_req(1'b0, 16'h0040, 1'b1, 1'b0, '0, 0);
    next_cycle();

    // Simultaneous I read and D write after reset: I first, then D.
    pulse_reset();
    fork
      do_req(1'b0, 16'h0100, 1'b1, 1'b0, '0, 0);
      do_req(1'b1, 16'h8000, 1'b0, 1'b1, {8{16'h1234}}, 0);
    join
    next_cycle();

    // Both continuously active: grants alternate I, D, I, D, I, D.
    mem_fixed = 1'b0;
    fork
      for (int k = 0; k < 3; k++) do_req(1'b0, 16'h1000 + 16'(k), 1'b1, 1'b0, rand_line(), 0);
      for (int k = 0; k < 3; k++) do_req(1'b1, 16'h2000 + 16'(k), 1'b0, 1'b1, rand_line(), 0);
    join
    next_cycle();

    // D moves its address while being served: the latched command must not.
    mem_fixed = 1'b1;
    fork
      do_req(1'b1, 16'h8000, 1'b1, 1'b0, '0, 0);
      begin
        next_cycle();
        next_cycle();
        d_pmem_address = 16'h9000;
      end
    join
    next_cycle();

    // I raises read and write together: only a write reaches memory.
    do_req(1'b0, 16'h0200, 1'b1, 1'b1, {4{32'hCAFEF00D}}, 0);
    next_cycle();

    // Reset two cycles into a D read, then a stray resp, then a normal I read.
    mem_auto = 1'b0;
    set_req(1'b1, 16'h0300, 1'b1, 1'b0, '0);
    push_req(1'b1, 16'h0300, 1'b1, 1'b0, '0);
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    d_pmem_read = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    stray_req++;
    next_cycle();
    next_cycle();
    mem_auto = 1'b1;
    do_req(1'b0, 16'h0400, 1'b1, 1'b0, '0, 0);
    next_cycle();

    // Random traffic from both caches with random memory latency and drops.
    mem_fixed = 1'b0;
    pulse_reset();
    fork
      rand_traffic(1'b0, 40);
      rand_traffic(1'b1, 40);
    join
    repeat (10) next_cycle();

    check("i_queue_drained", 32'(i_q.size()), '0);
    check("d_queue_drained", 32'(d_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
